// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_INCR    = 4;
    localparam int unsigned WORD_SHIFT = 2;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: aligned redirect target, sequential advance, or hold.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             advance,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] next_pc_c
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(PC_INCR - 1);

    // Redirect wins over sequential advance; otherwise the PC holds.
    always_comb begin
        next_pc_c = pc;
        if (redirect_valid) begin
            next_pc_c = redirect_target & ALIGN_MASK;
        end else if (advance) begin
            next_pc_c = pc + WIDTH'(PC_INCR);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, fetch FSM and registered decoder-facing output stage.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned      IMEM_DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4,
    output logic             halted,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_redirect_cnt
);

    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ~WIDTH'(PC_INCR - 1);
    localparam logic [WIDTH-1:0] DEPTH_W          = WIDTH'(IMEM_DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc_c;
    fetch_state_e     state;
    fetch_state_e     state_next;
    logic             in_range;
    logic             slot_free;
    logic             load;

    // Memory address depends only on the PC register.
    assign imem_addr = pc >> WORD_SHIFT;
    assign in_range  = imem_addr < DEPTH_W;
    assign slot_free = !out_valid || out_ready;

    // Next-state and load decision.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (state == FETCH_RUN) begin
            load = in_range && slot_free;
        end
        if (redirect_valid) begin
            state_next = FETCH_RUN;
        end else if (state == FETCH_RUN && !in_range && slot_free) begin
            state_next = FETCH_HALT;
        end
    end

    fetch_next_pc #(
        .WIDTH(WIDTH)
    ) u_next_pc (
        .pc              (pc),
        .advance         (load),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .next_pc_c       (next_pc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH_RUN;
            halted <= 1'b0;
            pc     <= RESET_PC_ALIGNED;
        end else begin
            state  <= state_next;
            halted <= (state_next == FETCH_HALT);
            pc     <= next_pc_c;
        end
    end

    // Output register: flush on redirect, refill on load, drain on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_pc       <= '0;
            out_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_instr    <= imem_instr;
            out_pc       <= pc;
            out_pc_plus4 <= pc + WIDTH'(PC_INCR);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // A flushed-but-accepted instruction still counts as fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt    = '0;
    assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: instruction-stream reference model plus
// directed timing checks and randomized ready/redirect traffic.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;

    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

    instr_fetch_unit #(
        .WIDTH      (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (imem_addr),
        .imem_instr        (imem_instr),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_pc            (out_pc),
        .out_pc_plus4      (out_pc_plus4),
        .halted            (halted),
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_valid;
    bit          m_halted;
    logic [31:0] m_nxt;
    logic [31:0] m_fcnt;
    logic [31:0] m_rcnt;

    function automatic bit fetchable(input logic [31:0] a);
        return (a / 4) < 32'(DEPTH);
    endfunction

    // Reference model: the decoder sees the instruction stream starting at the
    // reset PC, advancing by 4, restarting at each redirect target, ending at memory end.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_halted = 1'b0;
            m_nxt    = 32'h0;
            m_fcnt   = 32'd0;
            m_rcnt   = 32'd0;
            exp_q.delete();
        end else begin
            if (m_valid && out_ready) m_fcnt = m_fcnt + 32'd1;
            if (redirect_valid) begin
                m_rcnt = m_rcnt + 32'd1;
                if (m_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
                m_valid  = 1'b0;
                m_halted = 1'b0;
                m_nxt    = redirect_target & ~32'h3;
            end else if (m_valid && !out_ready) begin
                m_valid = 1'b1;
            end else if (fetchable(m_nxt)) begin
                exp_q.push_back('{pc: m_nxt, instr: mem[m_nxt[6:2]], pc4: m_nxt + 32'd4});
                m_valid = 1'b1;
                m_nxt   = m_nxt + 32'd4;
            end else begin
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end
        end
    end

    // Monitor: compares presented outputs against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("halted", 32'(halted), 32'(m_halted));
            check("imem_addr", imem_addr, m_nxt >> 2);
`ifdef FETCH_PERF_CNT_EN
            check("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
            check("perf_redirect_cnt", perf_redirect_cnt, m_rcnt);
`else
            check("perf_fetch_cnt", perf_fetch_cnt, 32'd0);
            check("perf_redirect_cnt", perf_redirect_cnt, 32'd0);
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got out_pc 0x%08h expected no valid output at %0t",
                             out_pc, $time);
                end else begin
                    check("out_pc", out_pc, exp_q[0].pc);
                    check("out_instr", out_instr, exp_q[0].instr);
                    check("out_pc_plus4", out_pc_plus4, exp_q[0].pc4);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic random_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            out_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid  = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom_range(0, 140);
        end
    endtask

    initial begin
        int wait_cnt;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_pc_plus4", out_pc_plus4, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);

        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h11);

        wait_cnt = 0;
        while (!(out_valid && out_pc == 32'd8) && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        check("reach_pc8", out_pc, 32'd8);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", out_pc, 32'd8);
            check("stall_instr", out_instr, 32'h33);
            check("stall_imem_addr", imem_addr, 32'd3);
        end
        out_ready = 1'b1;
        tick();
        check("release_instr", out_instr, 32'h44);

        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0013;
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble", 32'(out_valid), 32'd0);
        check("redir_imem_addr", imem_addr, 32'd4);
        out_ready = 1'b1;
        tick();
        check("redir_pc", out_pc, 32'h10);

        wait_cnt = 0;
        while (!halted && wait_cnt < 60) begin
            tick();
            wait_cnt++;
        end
        check("halt_reached", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_valid", 32'(out_valid), 32'd0);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("unhalt", 32'(halted), 32'd0);
        tick();
        check("unhalt_pc", out_pc, 32'h0);

        random_traffic(400);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_halted", 32'(halted), 32'd0);
        check("async_fetch_cnt", perf_fetch_cnt, 32'd0);
        check("async_redirect_cnt", perf_redirect_cnt, 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_pc", out_pc, 32'h0);

        random_traffic(300);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
